// File: rtl/oled_spi_sink_if.sv
// Pin-level bundle between an OLED transmit path and oled_spi_sink.
// master drives the serial pins, slave decodes them into display state.
interface oled_spi_sink_if;
  logic       CS;
  logic       SCLK;
  logic       SDIN;
  logic       DC;
  logic       RES;
  logic       fb_we;
  logic [8:0] fb_addr;
  logic [7:0] fb_data;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       display_on;
  logic [7:0] contrast;
  logic       charge_pump;
  logic       frame_err;

  modport master (
    output CS, SCLK, SDIN, DC, RES,
    input  fb_we, fb_addr, fb_data,
    input  cmd_valid, cmd_byte,
    input  display_on, contrast,
    input  charge_pump, frame_err
  );

  modport slave (
    input  CS, SCLK, SDIN, DC, RES,
    output fb_we, fb_addr, fb_data,
    output cmd_valid, cmd_byte,
    output display_on, contrast,
    output charge_pump, frame_err
  );
endinterface

// File: rtl/oled_spi_sink.sv
// Receive-side SSD1306 model: deserialises SDIN/SCLK/DC and decodes
// commands, arguments and framebuffer writes for the PmodOLED panel.
module oled_spi_sink #(
  parameter int NUM_PAGES = 4,
  parameter int NUM_COLS  = 128
) (
  input  logic CLK,
  input  logic RST,
  oled_spi_sink_if.slave pin
);

  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam logic [6:0] COL_MAX = 7'(NUM_COLS - 1);

  typedef enum logic {
    S_CMD = 1'b0,
    S_ARG = 1'b1
  } state_t;

  logic [2:0] sclk_q;
  logic [1:0] sdin_q;
  logic [1:0] dc_q;
  logic [1:0] cs_q;
  logic [1:0] res_q;

  logic [7:0] sh;
  logic [2:0] bit_cnt;

  state_t state;
  state_t state_n;

  logic [PW-1:0] page, page_n;
  logic [6:0]    col, col_n;
  logic [1:0]    arg_cnt, arg_n;
  logic [7:0]    op, op_n;

  logic       fb_we_q, we_n;
  logic [8:0] fb_addr_q, addr_n;
  logic [7:0] fb_data_q, data_n;
  logic       cmd_valid_q, cv_n;
  logic [7:0] cmd_byte_q, cb_n;
  logic       display_on_q, on_n;
  logic [7:0] contrast_q, con_n;
  logic       charge_pump_q, cp_n;
  logic       frame_err_q, err_n;

  logic       res_ok;
  logic       sck_rise;
  logic       strobe;
  logic       cs_err;
  logic [7:0] rx_byte;
  logic       rx_dc;
  logic [1:0] need;
  logic       is_disp;
  logic       is_col_lo;
  logic       is_col_hi;
  logic       is_page;

  function automatic logic [1:0] arg_need(input logic [7:0] b);
    case (b)
      8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB,
      8'h20:          arg_need = 2'd1;
      8'h21, 8'h22:   arg_need = 2'd2;
      default:        arg_need = 2'd0;
    endcase
  endfunction

  // Bring the pins into the CLK domain; SCLK gets one extra
  // stage so its edge detector lines up with SDIN/DC/CS.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sclk_q <= 3'b111;
      sdin_q <= 2'b00;
      dc_q   <= 2'b00;
      cs_q   <= 2'b11;
      res_q  <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], pin.SCLK};
      sdin_q <= {sdin_q[0], pin.SDIN};
      dc_q   <= {dc_q[0], pin.DC};
      cs_q   <= {cs_q[0], pin.CS};
      res_q  <= {res_q[0], pin.RES};
    end
  end

  assign res_ok    = res_q[1];
  assign sck_rise  = (sclk_q[2:1] == 2'b01) && !cs_q[1];
  assign rx_byte   = {sh[6:0], sdin_q[1]};
  assign rx_dc     = dc_q[1];
  assign strobe    = res_ok && sck_rise
                     && (bit_cnt == 3'd7);
  assign cs_err    = res_ok && cs_q[1]
                     && (bit_cnt != 3'd0);
  assign need      = arg_need(rx_byte);
  assign is_disp   = rx_byte[7:1] == 7'b1010_111;
  assign is_col_lo = rx_byte[7:4] == 4'h0;
  assign is_col_hi = rx_byte[7:4] == 4'h1;
  assign is_page   = rx_byte[7:3] == 5'b1011_0;

  // Shift register and bit counter; CS high drops a partial byte.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh      <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (!res_ok) begin
      sh      <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (cs_q[1]) begin
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      sh      <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Decoder state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_CMD;
    else      state <= state_n;
  end

  // Decoder next state: data bytes always land back in S_CMD.
  always_comb begin
    state_n = state;
    if (!res_ok) begin
      state_n = S_CMD;
    end else if (strobe) begin
      if (rx_dc) begin
        state_n = S_CMD;
      end else if (state == S_CMD) begin
        if (need != 2'd0) state_n = S_ARG;
      end else if (arg_cnt == 2'd1) begin
        state_n = S_CMD;
      end
    end
  end

  // Decoder outputs and address/argument bookkeeping.
  always_comb begin
    page_n = page;
    col_n  = col;
    arg_n  = arg_cnt;
    op_n   = op;
    we_n   = 1'b0;
    addr_n = fb_addr_q;
    data_n = fb_data_q;
    cv_n   = 1'b0;
    cb_n   = cmd_byte_q;
    on_n   = display_on_q;
    con_n  = contrast_q;
    cp_n   = charge_pump_q;
    err_n  = frame_err_q | cs_err;
    if (!res_ok) begin
      page_n = '0;
      col_n  = 7'd0;
      arg_n  = 2'd0;
      op_n   = 8'h00;
      addr_n = 9'd0;
      data_n = 8'h00;
      cb_n   = 8'h00;
      on_n   = 1'b0;
      con_n  = 8'h7F;
      cp_n   = 1'b0;
      err_n  = 1'b0;
    end else if (strobe) begin
      if (rx_dc) begin
        we_n   = 1'b1;
        addr_n = 9'({page, col});
        data_n = rx_byte;
        col_n  = (col == COL_MAX) ? 7'd0
                                  : col + 7'd1;
        if (state == S_ARG) begin
          err_n = 1'b1;
          arg_n = 2'd0;
        end
      end else begin
        cv_n = 1'b1;
        cb_n = rx_byte;
        if (state == S_ARG) begin
          arg_n = arg_cnt - 2'd1;
          if (op == 8'h81) con_n = rx_byte;
          if (op == 8'h8D) cp_n  = rx_byte[2];
        end else begin
          unique case (1'b1)
            is_disp:   on_n = rx_byte[0];
            is_col_lo: col_n[3:0] = rx_byte[3:0];
            is_col_hi: col_n[6:4] = rx_byte[2:0];
            is_page:   page_n = rx_byte[PW-1:0];
            (need != 2'd0): begin
              arg_n = need;
              op_n  = rx_byte;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Register every decoder output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      page          <= '0;
      col           <= 7'd0;
      arg_cnt       <= 2'd0;
      op            <= 8'h00;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= 9'd0;
      fb_data_q     <= 8'h00;
      cmd_valid_q   <= 1'b0;
      cmd_byte_q    <= 8'h00;
      display_on_q  <= 1'b0;
      contrast_q    <= 8'h7F;
      charge_pump_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      page          <= page_n;
      col           <= col_n;
      arg_cnt       <= arg_n;
      op            <= op_n;
      fb_we_q       <= we_n;
      fb_addr_q     <= addr_n;
      fb_data_q     <= data_n;
      cmd_valid_q   <= cv_n;
      cmd_byte_q    <= cb_n;
      display_on_q  <= on_n;
      contrast_q    <= con_n;
      charge_pump_q <= cp_n;
      frame_err_q   <= err_n;
    end
  end

  assign pin.fb_we       = fb_we_q;
  assign pin.fb_addr     = fb_addr_q;
  assign pin.fb_data     = fb_data_q;
  assign pin.cmd_valid   = cmd_valid_q;
  assign pin.cmd_byte    = cmd_byte_q;
  assign pin.display_on  = display_on_q;
  assign pin.contrast    = contrast_q;
  assign pin.charge_pump = charge_pump_q;
  assign pin.frame_err   = frame_err_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: command, data, wrap,
// abort, partial-byte and RES scenarios with fixed expectations.
module tb_oled_spi_sink;

  logic CLK;
  logic RST;

  oled_spi_sink_if bus ();

  oled_spi_sink #(
    .NUM_PAGES(4),
    .NUM_COLS (128)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pin(bus)
  );

  int n_chk;
  int n_pass;

  logic [8:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [7:0] cv_b[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Log every strobe cycle; a stretched pulse logs twice.
  always @(negedge CLK) begin
    if (bus.fb_we) begin
      wr_a.push_back(bus.fb_addr);
      wr_d.push_back(bus.fb_data);
    end
    if (bus.cmd_valid) cv_b.push_back(bus.cmd_byte);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] wa(input int i);
    return (wr_a.size() > i) ? 32'(wr_a[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return (wr_d.size() > i) ? 32'(wr_d[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] cb(input int i);
    return (cv_b.size() > i) ? 32'(cv_b[i]) : 32'hDEAD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr();
    wr_a.delete();
    wr_d.delete();
    cv_b.delete();
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input logic dc,
                           input int n);
    for (int i = 0; i < n; i++) begin
      bus.SCLK = 1'b0;
      bus.SDIN = b[7-i];
      bus.DC   = dc;
      tick(4);
      bus.SCLK = 1'b1;
      tick(4);
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    send_bits(b, 1'b0, 8);
    tick(2);
  endtask

  task automatic dat(input logic [7:0] b);
    send_bits(b, 1'b1, 8);
    tick(2);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    RST = 1'b0;
    bus.CS = 1'b0;
    bus.SCLK = 1'b1;
    bus.SDIN = 1'b0;
    bus.DC = 1'b0;
    bus.RES = 1'b1;
    tick(4);
    chk("rst_contrast", 32'(bus.contrast), 32'h7F);
    chk("rst_disp", 32'(bus.display_on), 0);
    RST = 1'b1;
    tick(4);
    chk("rst_we", 32'(bus.fb_we), 0);
    chk("rst_addr", 32'(bus.fb_addr), 0);
    chk("rst_cv", 32'(bus.cmd_valid), 0);
    chk("rst_cb", 32'(bus.cmd_byte), 0);
    chk("rst_err", 32'(bus.frame_err), 0);
    chk("rst_cp", 32'(bus.charge_pump), 0);

    clr();
    cmd(8'hAF);
    chk("af_cv_n", cv_b.size(), 1);
    chk("af_cb", cb(0), 32'hAF);
    chk("af_we_n", wr_a.size(), 0);
    chk("af_on", 32'(bus.display_on), 1);

    clr();
    cmd(8'h81);
    cmd(8'h3C);
    chk("con_cv_n", cv_b.size(), 2);
    chk("con_cb1", cb(1), 32'h3C);
    chk("con_val", 32'(bus.contrast), 32'h3C);
    cmd(8'hAE);
    chk("ae_on", 32'(bus.display_on), 0);
    chk("ae_cv_n", cv_b.size(), 3);

    clr();
    cmd(8'hB2);
    cmd(8'h05);
    cmd(8'h13);
    dat(8'hA5);
    dat(8'h5A);
    chk("wr_n", wr_a.size(), 2);
    chk("wr0_a", wa(0), 32'h135);
    chk("wr0_d", wd(0), 32'hA5);
    chk("wr1_a", wa(1), 32'h136);
    chk("wr1_d", wd(1), 32'h5A);
    chk("wr_cv_n", cv_b.size(), 3);

    clr();
    cmd(8'h0F);
    cmd(8'h17);
    cmd(8'hB3);
    dat(8'h11);
    dat(8'h22);
    chk("wrap0_a", wa(0), 32'h1FF);
    chk("wrap0_d", wd(0), 32'h11);
    chk("wrap1_a", wa(1), 32'h180);
    chk("wrap1_d", wd(1), 32'h22);

    clr();
    cmd(8'h8D);
    dat(8'hFF);
    chk("abt_err", 32'(bus.frame_err), 1);
    chk("abt_we_n", wr_a.size(), 1);
    chk("abt_a", wa(0), 32'h181);
    chk("abt_d", wd(0), 32'hFF);
    chk("abt_cp", 32'(bus.charge_pump), 0);

    clr();
    send_bits(8'hAF, 1'b0, 5);
    bus.CS = 1'b1;
    tick(8);
    bus.CS = 1'b0;
    tick(4);
    chk("part_cv_n", cv_b.size(), 0);
    chk("part_err", 32'(bus.frame_err), 1);
    cmd(8'hAF);
    chk("part_next", cb(0), 32'hAF);
    chk("part_on", 32'(bus.display_on), 1);

    cmd(8'h81);
    cmd(8'h10);
    chk("c10", 32'(bus.contrast), 32'h10);
    send_bits(8'hFF, 1'b0, 3);
    bus.RES = 1'b0;
    tick(6);
    chk("res_con", 32'(bus.contrast), 32'h7F);
    chk("res_on", 32'(bus.display_on), 0);
    chk("res_err", 32'(bus.frame_err), 0);
    chk("res_cb", 32'(bus.cmd_byte), 0);
    bus.RES = 1'b1;
    tick(4);

    clr();
    cmd(8'hAF);
    chk("post_cb", cb(0), 32'hAF);
    chk("post_on", 32'(bus.display_on), 1);
    cmd(8'h21);
    cmd(8'h00);
    cmd(8'h7F);
    cmd(8'hAE);
    chk("two_arg_cv", cv_b.size(), 5);
    chk("two_arg_on", 32'(bus.display_on), 0);
    dat(8'h77);
    chk("post_a", wa(0), 32'h000);
    chk("post_d", wd(0), 32'h77);
    chk("post_err", 32'(bus.frame_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- Receive-side model of the PmodOLED display controller: deserialises the SDIN/SCLK/DC stream produced by the OLED init/example blocks and decodes SSD1306 command and data bytes.
- Data bytes are written into a framebuffer write port; decoded display state is exposed as registers.
- Sits on the board-side pins (loopback or bench), giving the team a synthesizable checker for the OLED transmit path.

Parameters:
- NUM_PAGES, 4, display pages (128x32 panel); page field width = clog2(NUM_PAGES).
- NUM_COLS, 128, columns per page; column field width = 7.

Ports:
- CLK  in  1  system clock; must be at least 4x SCLK frequency.
- RST  in  1  asynchronous active-low reset.
- CS  in  1  chip select, active low; tie 0 when unused.
- SCLK  in  1  serial clock, idles high; data is sampled on the rising edge.
- SDIN  in  1  serial data, MSB first.
- DC  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- RES  in  1  display reset pin, active low; clears decoder state synchronously.
- fb_we  out  1  one-cycle framebuffer write strobe.
- fb_addr  out  9  {page[1:0], col[6:0]}.
- fb_data  out  8  data byte (bit0 = top row of page).
- cmd_valid  out  1  one-cycle strobe per received command or argument byte.
- cmd_byte  out  8  last command or argument byte.
- display_on  out  1  set by 0xAF, cleared by 0xAE.
- contrast  out  8  argument of 0x81.
- charge_pump  out  1  bit2 of the 0x8D argument.
- frame_err  out  1  sticky protocol error flag; cleared only by reset or RES.

Behaviour:
- Input sync: SCLK passes through 3 flops and SDIN/DC/CS through 2 flops, all delay-matched. A rising edge is synced SCLK stages [2:1] = 01.
- Shift: on each detected edge with CS low, shift SDIN into a byte register and increment a 3-bit bit counter. On the 8th edge, the byte is complete and DC is captured.
- CS high: bit counter cleared. If the counter was nonzero, set frame_err (partial byte discarded).
- Outputs are registered. fb_we and cmd_valid assert exactly 1 CLK after the completing edge is detected, for 1 cycle.
- Decoder FSM:
  - S_CMD (waiting for an opcode): single-byte opcodes:
    - 0xAE/0xAF: display_on.
    - 0x00-0x0F: col[3:0].
    - 0x10-0x17: col[6:4] (0x18-0x1F: col[6:4] = low 3 bits).
    - 0xB0-0xB7: page = low bits.
    - All others: no effect.
  - Argument-taking opcodes load arg_cnt and enter S_ARG:
    - 1 argument: 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x20.
    - 2 arguments: 0x21, 0x22.
  - S_ARG: each DC=0 byte pulses cmd_valid and decrements arg_cnt; return to S_CMD at zero.
    - 0x81 argument -> contrast.
    - 0x8D argument -> charge_pump = arg[2].
    - Others are consumed and ignored (page addressing mode only).
- Data byte (DC=1):
  - Writes fb_data at the current {page, col}.
  - col increments; wraps NUM_COLS-1 -> 0 with page unchanged.
  - In S_ARG: abort the pending command, return to S_CMD, set frame_err, and still perform the write.
- RES low: synchronously returns FSM, page, col, bit counter, and all outputs to reset values. RES overrides a byte completing in the same cycle; no strobe is issued.
- Reset values (RST or RES):
  - fb_we = 0, fb_addr = 0, fb_data = 0
  - cmd_valid = 0, cmd_byte = 0
  - display_on = 0, contrast = 0x7F, charge_pump = 0, frame_err = 0
  - FSM = S_CMD.
- RST assertion mid-byte: state clears immediately. After release, reception restarts on the next byte boundary only after CS has been high once, or at the first edge if CS is tied low (counter starts at 0).

Test Plan:
- Send command 0xAF (DC=0) -> display_on=1, single cmd_valid pulse with cmd_byte=0xAF, no fb_we.
- Send 0x81, 0x3C -> two cmd_valid pulses; contrast=0x3C after the 2nd; FSM back in S_CMD (a following 0xAE clears display_on).
- Send 0xB2, 0x05, 0x13, then data 0xA5, 0x5A -> fb_we at addr {2,0x35}=0x135 data 0xA5, then 0x136 data 0x5A.
- Set col 127 (0x0F, 0x17), page 3; send two data bytes -> writes at 0x1FF then 0x180 (column wraps, page held).
- Send 0x8D then data byte 0xFF -> frame_err=1, write of 0xFF occurs, charge_pump unchanged; raise CS after 5 bits of the next byte -> no strobe, frame_err stays 1.
- Pulse RES low mid-byte after setting contrast=0x10 -> contrast=0x7F, display_on=0, frame_err=0; the next full byte decodes correctly.
